cdc_in_arb: RTL

Round-robin arbiter that shares the single USB_CDC IN byte stream between up to four byte producers, for example the MCU FIFO interface, a debug/trace port and a boot monitor. Each requester presents a valid/ready byte stream with a last-byte marker. The block grants one requester at a time and holds the grant until that requester's packet ends, its burst limit is reached, or it stalls past a timeout. Output is a registered stage that drives the USB_CDC IN port with stable data/valid until consumed.

---
 rtl/cdc_in_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cdc_in_arb.sv
// Round-robin arbiter sharing the USB_CDC IN byte stream between N_REQ producers.
// A grant is held until packet end, MAX_BURST bytes, or HOLD_TO idle cycles.
module cdc_in_arb #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16,
  parameter int HOLD_TO   = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic                 busy_o
);

  localparam int PW = (N_REQ > 2) ? 2 : 1;
  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);
  localparam logic [7:0] HOLD_TO_B   = 8'(HOLD_TO);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [PW-1:0]     last_reg, last_next;
  logic [7:0]        beat_reg, beat_next;
  logic [7:0]        to_reg, to_next;
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;

  logic              out_free;
  logic              g_valid;
  logic              g_last;
  logic [7:0]        g_data;
  logic              xfer;
  logic [7:0]        beat_inc;
  logic [7:0]        to_inc;
  logic              found;
  int                cand;

  // While granted, last_reg is the index of the current owner.
  assign out_free = ~valid_reg | in_ready_i;
  assign g_valid  = req_valid_i[last_reg];
  assign g_last   = req_last_i[last_reg];
  assign g_data   = req_data_i[8*int'(last_reg) +: 8];
  assign xfer     = g_valid & grant_reg[last_reg] & out_free;

  assign beat_inc = (beat_reg == 8'hFF) ? 8'hFF : beat_reg + 8'd1;
  assign to_inc   = (to_reg == 8'hFF) ? 8'hFF : to_reg + 8'd1;

  assign req_ready_o = grant_reg & {N_REQ{out_free}};
  assign grant_o     = grant_reg;
  assign in_data_o   = data_reg;
  assign in_valid_o  = valid_reg;
  assign busy_o      = (|grant_reg) | valid_reg;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    beat_next  = beat_reg;
    to_next    = to_reg;
    found      = 1'b0;
    cand       = 0;
    case (state_reg)
      IDLE: begin
        if (|req_valid_i) begin
          // First valid requester after the previous winner, wrapping.
          for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_reg) + i) % N_REQ;
            if (!found && req_valid_i[cand]) begin
              found     = 1'b1;
              last_next = PW'(cand);
            end
          end
          grant_next = {{(N_REQ-1){1'b0}}, 1'b1} << last_next;
          beat_next  = 8'd0;
          to_next    = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_next = beat_inc;
          to_next   = 8'd0;
          if (g_last || (beat_inc == MAX_BURST_B)) begin
            grant_next = '0;
            state_next = IDLE;
          end
        end else if (!g_valid) begin
          to_next = to_inc;
          if ((HOLD_TO_B != 8'd0) && (to_inc == HOLD_TO_B)) begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new load wins over consumption, so valid stays high across back-to-back bytes.
  always_comb begin
    data_next  = xfer ? g_data : data_reg;
    valid_next = xfer | (valid_reg & ~in_ready_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= PW'(N_REQ - 1);
      beat_reg  <= 8'd0;
      to_reg    <= 8'd0;
      data_reg  <= 8'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      beat_reg  <= beat_next;
      to_reg    <= to_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

endmodule
